// File: rtl/cdc_loopback_fifo.sv
// cdc_loopback_fifo: echoes usb_cdc OUT bytes back on the IN endpoint in threshold/idle-triggered bursts.
// Build option CDC_LOOPBACK_UPPERCASE_EN folds ASCII a-z to upper case at the write stage.
//   state | meaning
//   FILL  | collecting bytes, IN side quiet
//   DRAIN | streaming stored bytes to the IN endpoint
module cdc_loopback_fifo #(
    parameter int DEPTH       = 64,
    parameter int THRESHOLD   = 16,
    parameter int IDLE_CYCLES = 1600,
    parameter int LED_CYCLES  = 800000
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [7:0]             out_data_i,
    input  logic                   out_valid_i,
    output logic                   out_ready_o,
    output logic [7:0]             in_data_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   led_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int CW = $clog2(LED_CYCLES + 1);
    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_THRESH = LW'(THRESHOLD);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES);
    localparam logic [CW-1:0] LED_MAX    = CW'(LED_CYCLES);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, mem_count;
    logic [IW-1:0] idle_q, idle_d;
    logic [CW-1:0] led_cnt_q, led_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          out_ready_q, out_ready_d;
    logic          in_valid_q, in_valid_d;
    logic [7:0]    in_data_q, in_data_d;
    logic          wr_fire, rd_fire, load_skid;

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef CDC_LOOPBACK_UPPERCASE_EN
        fold_byte = (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
`else
        fold_byte = b;
`endif
    endfunction

    always_comb begin
        wr_fire     = out_valid_i && out_ready_q;
        rd_fire     = in_valid_q && in_ready_i;
        level_d     = level_q + LW'(wr_fire) - LW'(rd_fire);
        out_ready_d = (level_d < LVL_FULL);

        // Bytes sitting in the write stage or the output skid are stored but not readable from memory.
        mem_count = level_q - LW'(in_valid_q) - LW'(wr_en_q);
        load_skid = (state_q == DRAIN) && (mem_count != '0) && (!in_valid_q || in_ready_i);

        wr_en_d   = wr_fire;
        wr_data_d = wr_fire ? fold_byte(out_data_i) : wr_data_q;
        wr_ptr_d  = wr_en_q ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = load_skid ? rd_ptr_q + PW'(1) : rd_ptr_q;

        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        if (load_skid) begin
            in_valid_d = 1'b1;
            in_data_d  = mem_q[rd_ptr_q];
        end else if (rd_fire) begin
            in_valid_d = 1'b0;
        end

        if (wr_fire)
            idle_d = '0;
        else if (idle_q == IDLE_MAX)
            idle_d = idle_q;
        else
            idle_d = idle_q + IW'(1);

        if (wr_fire || rd_fire)
            led_cnt_d = LED_MAX;
        else if (led_cnt_q != '0)
            led_cnt_d = led_cnt_q - CW'(1);
        else
            led_cnt_d = led_cnt_q;

        state_d = state_q;
        case (state_q)
            FILL:  if (level_d >= LVL_THRESH || (idle_d == IDLE_MAX && level_d != '0))
                       state_d = DRAIN;
            DRAIN: if (level_d == '0)
                       state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            idle_q      <= '0;
            led_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            out_ready_q <= 1'b0;
            in_valid_q  <= 1'b0;
            in_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            idle_q      <= idle_d;
            led_cnt_q   <= led_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            out_ready_q <= out_ready_d;
            in_valid_q  <= in_valid_d;
            in_data_q   <= in_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_q)
            mem_q[wr_ptr_q] <= wr_data_q;
    end

    assign out_ready_o = out_ready_q;
    assign in_valid_o  = in_valid_q;
    assign in_data_o   = in_data_q;
    assign level_o     = level_q;
    assign led_o       = (led_cnt_q != '0);
endmodule

// File: tb/tb_cdc_loopback_fifo.sv
// Bench for cdc_loopback_fifo: directed corner sequences, a vector table and a randomized stream
// checked against a queue-based model of the byte stream and fill level.
module tb_cdc_loopback_fifo;
    localparam int DEPTH = 64;
    localparam int THRESH = 16;
    localparam int IDLE = 40;
    localparam int LEDC = 60;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [7:0]    out_data_i;
    logic          out_valid_i;
    logic          out_ready_o;
    logic [7:0]    in_data_o;
    logic          in_valid_o;
    logic          in_ready_i;
    logic [LW-1:0] level_o;
    logic          led_o;

    cdc_loopback_fifo #(
        .DEPTH(DEPTH), .THRESHOLD(THRESH), .IDLE_CYCLES(IDLE), .LED_CYCLES(LEDC)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .level_o(level_o), .led_o(led_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] din; logic [7:0] dexp; } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   exp_level = 0;
    bq_t  exp_q;
    bq_t  rx_q;

    function automatic logic [7:0] tb_fold(input logic [7:0] b);
`ifdef CDC_LOOPBACK_UPPERCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Model: every handshake seen at the falling edge takes effect at the following rising edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("level", 32'(level_o), 32'(exp_level));
            if (!rstn_i) begin
                exp_q.delete();
                exp_level = 0;
            end else begin
                if (in_valid_o && in_ready_i) begin
                    if (exp_q.size() == 0) begin
                        timeout("read_with_nothing_stored");
                    end else begin
                        chk("rd_data", 32'(in_data_o), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    rx_q.push_back(in_data_o);
                    exp_level--;
                end
                if (out_valid_i && out_ready_o) begin
                    exp_q.push_back(tb_fold(out_data_i));
                    exp_level++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (out_ready_o) break;
            g++;
            if (g > 5000) begin
                timeout("send_byte");
                break;
            end
        end
        cyc();
        out_valid_i = 1'b0;
    endtask

    task automatic wait_drained(input string nm);
        int g = 0;
        do begin
            @(negedge clk_i);
            g++;
        end while (!(level_o == '0 && !in_valid_o) && g < 3000);
        if (g >= 3000) timeout(nm);
        cyc();
    endtask

    task automatic check_rx(input string nm, input bq_t e);
        chk($sformatf("%s_count", nm), 32'(rx_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]), 32'(e[i]));
    endtask

    initial begin
        vec_t     tbl[8];
        bq_t      e;
        int       k;
        logic [7:0] rb;
        logic     e_done;

        tbl[0] = '{8'h61, 8'h61}; tbl[1] = '{8'h7A, 8'h7A}; tbl[2] = '{8'h7B, 8'h7B};
        tbl[3] = '{8'h41, 8'h41}; tbl[4] = '{8'h60, 8'h60}; tbl[5] = '{8'h6D, 8'h6D};
        tbl[6] = '{8'h00, 8'h00}; tbl[7] = '{8'hFF, 8'hFF};
`ifdef CDC_LOOPBACK_UPPERCASE_EN
        tbl[0].dexp = 8'h41; tbl[1].dexp = 8'h5A; tbl[5].dexp = 8'h4D;
`endif

        rstn_i = 1'b0; out_data_i = '0; out_valid_i = 1'b0; in_ready_i = 1'b0;
        cyc();
        mon_en = 1'b1;
        cyc();
        chk("rst_out_ready", 32'(out_ready_o), 0);
        chk("rst_in_valid", 32'(in_valid_o), 0);
        chk("rst_in_data", 32'(in_data_o), 0);
        chk("rst_led", 32'(led_o), 0);
        rstn_i = 1'b1;
        cyc();
        chk("rst_rel_out_ready", 32'(out_ready_o), 1);

        // Reset mid-stream with 10 bytes stored.
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        chk("a_level10", 32'(level_o), 10);
        rstn_i = 1'b0;
        repeat (5) cyc();
        rstn_i = 1'b1;
        cyc();
        chk("a_level", 32'(level_o), 0);
        chk("a_in_valid", 32'(in_valid_o), 0);
        chk("a_led", 32'(led_o), 0);
        chk("a_out_ready", 32'(out_ready_o), 1);

        // Short message released by idle timeout.
        in_ready_i = 1'b1;
        rx_q.delete(); e.delete();
        for (int i = 1; i <= 7; i++) begin
            send_byte(8'(i));
            e.push_back(8'(i));
        end
        k = 0;
        forever begin
            @(negedge clk_i);
            if (in_valid_o || k > 4 * IDLE) break;
            k++;
        end
        chk("b_idle_quiet", 32'(k >= IDLE), 1);
        chk("b_idle_prompt", 32'(k <= IDLE + 3), 1);
        wait_drained("b_drain");
        check_rx("b_rx", e);
        chk("b_led_on", 32'(led_o), 1);

        // Threshold burst.
        rx_q.delete(); e.delete();
        for (int i = 0; i < 16; i++) begin
            rb = (i < 8) ? 8'h11 + 8'(i) : 8'h31 + 8'(i - 8);
            e.push_back(rb);
            send_byte(rb);
        end
        chk("c_level16", 32'(level_o), 16);
        chk("c_no_out_yet", 32'(in_valid_o), 0);
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("c_nogap%0d", i), 32'(in_valid_o), 1);
            cyc();
        end
        wait_drained("c_drain");
        check_rx("c_rx", e);

        // Fill to full with IN stalled, then hold the 65th byte.
        in_ready_i = 1'b0;
        rx_q.delete(); e.delete();
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i));
            e.push_back(8'(i));
        end
        chk("d_level_full", 32'(level_o), 64);
        chk("d_ready_low", 32'(out_ready_o), 0);
        out_data_i = 8'd64; out_valid_i = 1'b1;
        repeat (3) cyc();
        chk("d_held_level", 32'(level_o), 64);
        chk("d_held_ready", 32'(out_ready_o), 0);
        in_ready_i = 1'b1;
        send_byte(8'd64);
        e.push_back(8'd64);
        wait_drained("d_drain");
        check_rx("d_rx", e);

        // Random IN backpressure over a long stream spanning pointer wrap.
        rx_q.delete(); e.delete();
        e_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    rb = 8'($urandom);
                    e.push_back(tb_fold(rb));
                    send_byte(rb);
                end
                e_done = 1'b1;
            end
            begin
                while (!e_done) begin
                    in_ready_i = 1'($urandom_range(0, 1));
                    cyc();
                end
            end
        join
        in_ready_i = 1'b1;
        wait_drained("e_drain");
        check_rx("e_rx", e);

        // Vector table through the optional transform.
        rx_q.delete(); e.delete();
        for (int i = 0; i < 8; i++) send_byte(tbl[i].din);
        wait_drained("f_drain");
        chk("f_count", 32'(rx_q.size()), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            chk($sformatf("f_vec%0d", i), 32'(rx_q[i]), 32'(tbl[i].dexp));

        chk("f_led_on", 32'(led_o), 1);
        repeat (LEDC - 10) cyc();
        chk("f_led_stretch", 32'(led_o), 1);
        repeat (12) cyc();
        chk("f_led_off", 32'(led_o), 0);
        chk("f_model_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
